// File: rtl/hs_pkg.sv
// hs_pkg: shared FSM states, request/response handshake types and the response formatter
package hs_pkg;
  localparam int REQ_W = 3;
  localparam int RSP_W = 4;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;
  typedef struct packed {
    logic             valid;
    logic [REQ_W-1:0] data;
  } hs_req_t;
  typedef struct packed {
    logic             valid;
    logic [RSP_W-1:0] data;
  } hs_rsp_t;
  function automatic logic [RSP_W-1:0] rsp_fmt(input logic [REQ_W-1:0] d);
    return {d, ^d};
  endfunction
endpackage

// File: rtl/hs_lat_cnt.sv
// hs_lat_cnt: loadable down-counter that holds at zero
// ports: clk, rst (sync, active-high), load_i/val_i load a count, dec_i decrements, cnt_o current count
module hs_lat_cnt
  import hs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [LAT_W-1:0] val_i,
  output logic [LAT_W-1:0] cnt_o
);
  logic [LAT_W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - LAT_W'(1) : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/hs_responder.sv
// hs_responder: single-outstanding request/response slave with fixed processing latency
// ports: sys_clk, sys_rst (sync, active-high); req_valid/req_data/req_ready request side;
//        rsp_valid/rsp_data/rsp_ready response side; txn_cnt completed responses (wraps);
//        proto_err sticky master-violation flag, present only when HS_RESPONDER_CHK_EN is defined
module hs_responder
  import hs_pkg::*;
#(
  parameter int PROC_LAT = 2,
  parameter int CNT_W    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req_valid,
  input  logic [2:0]       req_data,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [3:0]       rsp_data,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] txn_cnt
`ifdef HS_RESPONDER_CHK_EN
  ,
  output logic             proto_err
`endif
);
  state_e           state_q, state_d;
  logic             rdy_q, vld_q, acc, hs;
  logic [3:0]       data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LAT_W-1:0] lat;
  assign acc = req_valid & rdy_q;
  assign hs  = vld_q & rsp_ready;
  hs_lat_cnt u_lat (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .load_i(acc),
    .dec_i (state_q == CALC),
    .val_i (LAT_W'(PROC_LAT)),
    .cnt_o (lat)
  );
  // the final CALC cycle is the one where the counter still reads 1
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (acc ? (PROC_LAT == 0 ? RESP : CALC) : IDLE) :
              state_q == CALC ? (lat == LAT_W'(1) ? RESP : CALC) :
              (hs ? IDLE : RESP);
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d == IDLE;
      vld_q   <= state_d == RESP;
      if (acc) data_q <= rsp_fmt(req_data);
      if (hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_data  = data_q;
  assign txn_cnt   = cnt_q;
`ifdef HS_RESPONDER_CHK_EN
  // pend_q: last cycle had a stalled response while the master drove a request
  logic       pend_q, err_q;
  logic [2:0] pd_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend_q <= 1'b0;
      pd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= vld_q & ~rsp_ready & req_valid;
      pd_q   <= req_data;
      if (state_q == RESP && pend_q && (!req_valid || req_data != pd_q)) err_q <= 1'b1;
    end
  end
  assign proto_err = err_q;
`endif
endmodule
